// File: rtl/nbit_count_up_down.sv
// nbit_count_up_down: N-bit unsigned up/down counter.
// Features: synchronous load, count enable, and either modulo wrap or
// saturation at the bounds. The wrap and sat outputs are registered
// one-cycle pulses. The port reset_n keeps its legacy name, but the
// reset it carries is asynchronous and ACTIVE-HIGH.
module nbit_count_up_down #(
    parameter int                   CNT_WIDTH = 3,
    parameter bit                   SATURATE  = 1'b0,
    parameter logic [CNT_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 count_up_down,
    input  logic                 en,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_val,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 at_max,
    output logic                 at_min,
    output logic                 wrap,
    output logic                 sat
);

    localparam logic [CNT_WIDTH-1:0] MAX_VAL = '1;
    localparam logic [CNT_WIDTH-1:0] MIN_VAL = '0;
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] next_cnt;
    logic                 next_wrap;
    logic                 next_sat;

    // Bound flags are decoded from the registered count only.
    // This keeps them meaningful while reset is asserted.
    assign at_max = (counter == MAX_VAL);
    assign at_min = (counter == MIN_VAL);

    // Next-state decode, priority load > enabled count > hold.
    // A blocked step either wraps or saturates, depending on SATURATE.
    always_comb begin
        next_cnt  = counter;
        next_wrap = 1'b0;
        next_sat  = 1'b0;
        if (load) begin
            next_cnt = load_val;
        end else if (en) begin
            if (count_up_down) begin
                if (counter == MAX_VAL) begin
                    if (SATURATE) begin
                        next_sat  = 1'b1;
                    end else begin
                        next_cnt  = MIN_VAL;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_cnt = counter + ONE;
                end
            end else begin
                if (counter == MIN_VAL) begin
                    if (SATURATE) begin
                        next_sat  = 1'b1;
                    end else begin
                        next_cnt  = MAX_VAL;
                        next_wrap = 1'b1;
                    end
                end else begin
                    next_cnt = counter - ONE;
                end
            end
        end
    end

    // Count and pulse registers.
    // The asynchronous active-high reset clears them immediately.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            counter <= RESET_VAL;
            wrap    <= 1'b0;
            sat     <= 1'b0;
        end else begin
            counter <= next_cnt;
            wrap    <= next_wrap;
            sat     <= next_sat;
        end
    end

endmodule

// File: tb/tb_nbit_count_up_down.sv
// Directed bench for nbit_count_up_down.
// A wrapping instance and a saturating instance share the same stimulus.
module tb_nbit_count_up_down;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       dir;
    logic       en;
    logic       load;
    logic [2:0] load_val;

    logic [2:0] cnt_w, cnt_s;
    logic       max_w, min_w, wrap_w, sat_w;
    logic       max_s, min_s, wrap_s, sat_s;

    int tests = 0;
    int fails = 0;

    nbit_count_up_down #(.CNT_WIDTH(3), .SATURATE(1'b0), .RESET_VAL(3'd0)) dut_w (
        .clk(clk), .reset_n(reset_n), .count_up_down(dir), .en(en), .load(load),
        .load_val(load_val), .counter(cnt_w), .at_max(max_w), .at_min(min_w),
        .wrap(wrap_w), .sat(sat_w)
    );

    nbit_count_up_down #(.CNT_WIDTH(3), .SATURATE(1'b1), .RESET_VAL(3'd0)) dut_s (
        .clk(clk), .reset_n(reset_n), .count_up_down(dir), .en(en), .load(load),
        .load_val(load_val), .counter(cnt_s), .at_max(max_s), .at_min(min_s),
        .wrap(wrap_s), .sat(sat_s)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then settle for sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges; leave the counters at 0 and idle
    task automatic do_reset();
        reset_n = 1'b1;
        en      = 1'b0;
        load    = 1'b0;
        #3;
        reset_n = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        dir      = 1'bx;
        en       = 1'bx;
        load     = 1'bx;
        load_val = 3'bxxx;
        tick();
        tick();
        tests++;
        if (cnt_w !== 3'd0 || wrap_w !== 1'b0 || sat_w !== 1'b0 || min_w !== 1'b1 || max_w !== 1'b0) begin
            fails++;
            $display("FAIL reset_w: cnt=%0d wrap=%b sat=%b min=%b max=%b, expected 0 0 0 1 0",
                     cnt_w, wrap_w, sat_w, min_w, max_w);
        end
        tests++;
        if (cnt_s !== 3'd0 || sat_s !== 1'b0 || min_s !== 1'b1) begin
            fails++;
            $display("FAIL reset_s: cnt=%0d sat=%b min=%b, expected 0 0 1", cnt_s, sat_s, min_s);
        end
        // Release with a load, then re-assert reset between edges
        en       = 1'b0;
        load     = 1'b1;
        load_val = 3'd6;
        dir      = 1'b1;
        #2;
        reset_n = 1'b0;
        tick();
        load = 1'b0;
        tests++;
        if (cnt_w !== 3'd6) begin
            fails++;
            $display("FAIL reset_load: got %0d expected 6", cnt_w);
        end
        #2;
        reset_n = 1'b1;
        #1;
        tests++;
        if (cnt_w !== 3'd0 || min_w !== 1'b1) begin
            fails++;
            $display("FAIL reset_async: cnt=%0d min=%b, expected 0 1", cnt_w, min_w);
        end
        #1;
        reset_n = 1'b0;
    endtask

    task automatic test_up_wrap();
        int exp_c[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        do_reset();
        dir = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (cnt_w !== 3'(exp_c[i]) || wrap_w !== (i == 7) ||
                max_w !== (exp_c[i] == 7) || min_w !== (exp_c[i] == 0)) begin
                fails++;
                $display("FAIL up_wrap[%0d]: cnt=%0d wrap=%b max=%b min=%b, expected cnt=%0d wrap=%b",
                         i, cnt_w, wrap_w, max_w, min_w, exp_c[i], (i == 7));
            end
        end
    endtask

    task automatic test_down_wrap();
        int exp_c[6] = '{3, 2, 1, 0, 7, 6};
        en       = 1'b0;
        load     = 1'b1;
        load_val = 3'd4;
        tick();
        load = 1'b0;
        tests++;
        if (cnt_w !== 3'd4 || wrap_w !== 1'b0) begin
            fails++;
            $display("FAIL down_load: cnt=%0d wrap=%b, expected 4 0", cnt_w, wrap_w);
        end
        dir = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (cnt_w !== 3'(exp_c[i]) || wrap_w !== (i == 4)) begin
                fails++;
                $display("FAIL down_wrap[%0d]: cnt=%0d wrap=%b, expected %0d %b",
                         i, cnt_w, wrap_w, exp_c[i], (i == 4));
            end
        end
    endtask

    task automatic test_dir_change();
        int exp_c[9] = '{1, 2, 3, 4, 3, 2, 1, 0, 7};
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            dir = (i < 4);
            tick();
            tests++;
            if (cnt_w !== 3'(exp_c[i]) || wrap_w !== (i == 8)) begin
                fails++;
                $display("FAIL dir_change[%0d]: cnt=%0d wrap=%b, expected %0d %b",
                         i, cnt_w, wrap_w, exp_c[i], (i == 8));
            end
        end
    endtask

    task automatic test_load();
        load     = 1'b1;
        load_val = 3'd5;
        en       = 1'b1;
        dir      = 1'b1;
        tick();
        load = 1'b0;
        en   = 1'b0;
        tests++;
        if (cnt_w !== 3'd5 || wrap_w !== 1'b0) begin
            fails++;
            $display("FAIL load_prio: cnt=%0d wrap=%b, expected 5 0", cnt_w, wrap_w);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (cnt_w !== 3'd5) begin
                fails++;
                $display("FAIL load_hold[%0d]: got %0d expected 5", i, cnt_w);
            end
        end
        // Load following a wrap cycle clears the pulse
        load     = 1'b1;
        load_val = 3'd7;
        tick();
        load = 1'b0;
        en   = 1'b1;
        tick();
        tests++;
        if (cnt_w !== 3'd0 || wrap_w !== 1'b1) begin
            fails++;
            $display("FAIL load_wrap: cnt=%0d wrap=%b, expected 0 1", cnt_w, wrap_w);
        end
        load     = 1'b1;
        load_val = 3'd2;
        tick();
        load = 1'b0;
        en   = 1'b0;
        tests++;
        if (cnt_w !== 3'd2 || wrap_w !== 1'b0) begin
            fails++;
            $display("FAIL load_clear: cnt=%0d wrap=%b, expected 2 0", cnt_w, wrap_w);
        end
    endtask

    task automatic test_saturate();
        int up_c[9] = '{1, 2, 3, 4, 5, 6, 7, 7, 7};
        int dn_c[9] = '{6, 5, 4, 3, 2, 1, 0, 0, 0};
        do_reset();
        dir = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (cnt_s !== 3'(up_c[i]) || sat_s !== (i >= 7) || wrap_s !== 1'b0) begin
                fails++;
                $display("FAIL sat_up[%0d]: cnt=%0d sat=%b wrap=%b, expected %0d %b 0",
                         i, cnt_s, sat_s, wrap_s, up_c[i], (i >= 7));
            end
        end
        en = 1'b0;
        tick();
        tests++;
        if (cnt_s !== 3'd7 || sat_s !== 1'b0 || max_s !== 1'b1) begin
            fails++;
            $display("FAIL sat_hold: cnt=%0d sat=%b max=%b, expected 7 0 1", cnt_s, sat_s, max_s);
        end
        dir = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            tests++;
            if (cnt_s !== 3'(dn_c[i]) || sat_s !== (i >= 7) || wrap_s !== 1'b0) begin
                fails++;
                $display("FAIL sat_down[%0d]: cnt=%0d sat=%b wrap=%b, expected %0d %b 0",
                         i, cnt_s, sat_s, wrap_s, dn_c[i], (i >= 7));
            end
        end
        // Async reset in the middle of counting, then resume
        do_reset();
        dir = 1'b1;
        en  = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        tests++;
        if (cnt_s !== 3'd3) begin
            fails++;
            $display("FAIL sat_pre_reset: got %0d expected 3", cnt_s);
        end
        #1;
        reset_n = 1'b1;
        #1;
        tests++;
        if (cnt_s !== 3'd0 || sat_s !== 1'b0) begin
            fails++;
            $display("FAIL sat_async_reset: cnt=%0d sat=%b, expected 0 0", cnt_s, sat_s);
        end
        #1;
        reset_n = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests++;
            if (cnt_s !== 3'(i)) begin
                fails++;
                $display("FAIL sat_resume[%0d]: got %0d expected %0d", i, cnt_s, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_dir_change();
        test_load();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
